hazard_ctrl_fsm: RTL

//  Parametrised successor to hazard_control_unit: central stall/flush generator for the 5-stage RV32I pipeline.

---
 rtl/hazard_ctrl_fsm.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_fsm.sv
// Central stall/flush generator for the 5-stage RV32I pipeline: load-use bubbles,
// taken branch/jump flushes, IMEM/DMEM wait-state freezing and a stall perf counter.
module hazard_ctrl_fsm #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int BJ_FLUSH_STAGES  = 2,
    parameter int WAIT_MAX         = 15,
    parameter int CNT_W            = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_memread_i,
    input  logic             ex_take_b_j_i,
    input  logic             imem_ready_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic [1:0]       state_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_BJ_FLUSH = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic       LU_MULTI  = (LOAD_USE_BUBBLES > 1);
    localparam logic       BJ_EXTRA  = (BJ_FLUSH_STAGES == 3);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX);
    localparam logic [7:0] WAIT_PRE  = 8'(WAIT_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       saved_q, saved_d;
    logic [1:0]       bub_q, bub_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       lu_haz_s;
    logic       bj_s;
    logic       mem_wait_s;
    logic [1:0] eff_state_s;
    logic       stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
    logic       flush_if_id_s, flush_id_ex_s;
    logic       timeout_s;

    function automatic logic src_hit(input logic uses, input logic [4:0] src, input logic [4:0] rd);
        src_hit = uses & (src == rd);
    endfunction

    // Hazard detection terms
    always_comb begin
        lu_haz_s   = id_valid_i & ex_valid_i & ex_memread_i & (ex_rd_addr_i != 5'd0) &
                     (src_hit(id_uses_rs1_i, id_rs1_addr_i, ex_rd_addr_i) |
                      src_hit(id_uses_rs2_i, id_rs2_addr_i, ex_rd_addr_i));
        bj_s       = ex_valid_i & ex_take_b_j_i;
        mem_wait_s = dmem_req_i & ~dmem_ready_i;
        // On the DMEM release cycle the interrupted state is resumed as if never left
        eff_state_s = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
    end

    // Next-state, counters and stall/flush decode by priority
    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        bub_d         = bub_q;
        wait_d        = wait_q;
        stall_if_s    = 1'b0;
        stall_id_s    = 1'b0;
        stall_ex_s    = 1'b0;
        stall_mem_s   = 1'b0;
        flush_if_id_s = 1'b0;
        flush_id_ex_s = 1'b0;
        timeout_s     = 1'b0;

        if (mem_wait_s) begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            stall_ex_s  = 1'b1;
            stall_mem_s = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                saved_d = state_q;
            end else begin
                saved_d = saved_q;
            end
            if (wait_q != WAIT_LAST) begin
                wait_d = wait_q + 8'd1;
            end else begin
                wait_d = wait_q;
            end
            timeout_s = (wait_q == WAIT_PRE);
        end else if (bj_s) begin
            wait_d        = 8'd0;
            flush_if_id_s = 1'b1;
            flush_id_ex_s = 1'b1;
            bub_d         = 2'd0;
            if (BJ_EXTRA) begin
                state_d = ST_BJ_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            wait_d = 8'd0;
            case (eff_state_s)
                ST_RUN: begin
                    if (lu_haz_s) begin
                        stall_if_s    = 1'b1;
                        stall_id_s    = 1'b1;
                        flush_id_ex_s = 1'b1;
                        if (LU_MULTI) begin
                            state_d = ST_LU_STALL;
                            bub_d   = LU_RELOAD;
                        end else begin
                            state_d = ST_RUN;
                            bub_d   = 2'd0;
                        end
                    end else begin
                        state_d = ST_RUN;
                        if (!imem_ready_i) begin
                            stall_if_s    = 1'b1;
                            flush_if_id_s = 1'b1;
                        end else begin
                            stall_if_s    = 1'b0;
                            flush_if_id_s = 1'b0;
                        end
                    end
                end
                ST_LU_STALL: begin
                    stall_if_s    = 1'b1;
                    stall_id_s    = 1'b1;
                    flush_id_ex_s = 1'b1;
                    if (bub_q <= 2'd1) begin
                        state_d = ST_RUN;
                        bub_d   = 2'd0;
                    end else begin
                        state_d = ST_LU_STALL;
                        bub_d   = bub_q - 2'd1;
                    end
                end
                ST_BJ_FLUSH: begin
                    flush_if_id_s = 1'b1;
                    state_d       = ST_RUN;
                    if (!imem_ready_i) begin
                        stall_if_s = 1'b1;
                    end else begin
                        stall_if_s = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    bub_d   = 2'd0;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of the clock
    always_comb begin
        stall_if_o    = rst_i & stall_if_s;
        stall_id_o    = rst_i & stall_id_s;
        stall_ex_o    = rst_i & stall_ex_s;
        stall_mem_o   = rst_i & stall_mem_s;
        flush_if_id_o = rst_i & flush_if_id_s;
        flush_id_ex_o = rst_i & flush_id_ex_s;
        mem_timeout_o = rst_i & timeout_s;
        state_o       = state_q;
        stall_cnt_o   = stall_cnt_q;
    end

    // Saturating count of IF stall cycles
    always_comb begin
        if (stall_if_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            bub_q       <= 2'd0;
            wait_q      <= 8'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            bub_q       <= bub_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
